iq_stream_scheduler: RTL and testbench
======================================

Name: iq_stream_scheduler

Overview:
Round-robin scheduler that shares one two-word I/Q serializer (Avalon-ST sop/eop packetizer) between NUM_SRC decimated receive sources. Each source delivers one I/Q pair per strobe and cannot be back-pressured, so each has a 1-deep holding register. The block grants one pair at a time, presents it with out_valid/out_ready, tags it with the channel number, and then enforces a guard gap so the serializer returns to idle before the next grant. Sits between the decimation chains and the serializer feeding the USB/FIFO path.

Parameters:
NUM_SRC, 2, number of sources (2..4)
DATA_W, 24, width of each I/Q word
SLOT_GAP, 4, cycles with out_valid=0 after each transfer (1..15)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
src_strobe  in  NUM_SRC  bit k: one-cycle pulse, new pair on source k
src_data_1  in  NUM_SRC*DATA_W  I word; source k in bits [k*DATA_W +: DATA_W]
src_data_2  in  NUM_SRC*DATA_W  Q word, same packing
out_data_1  out  DATA_W  granted I word
out_data_2  out  DATA_W  granted Q word
out_chan  out  2  index of the granted source
out_valid  out  1  granted pair valid
out_ready  in  1  serializer accepts pair
overrun  out  NUM_SRC  sticky per-source overrun flags
overrun_clr  in  1  clears all overrun flags
busy  out  1  high in ISSUE and GAP

Behaviour:
- Reset (reset_n=0 at an edge): out_data_1/2=0, out_chan=0, out_valid=0, overrun=0, busy=0, all pending=0, rr_ptr=0, gap counter=0, state=IDLE. Mid-transfer reset discards held and issued data.
- Capture: src_strobe[k] at an edge -> hold_k loaded from its slice, pending[k]=1 from the next cycle.
- Overrun: strobe[k] while pending[k]=1 and source k not granted at that edge -> data overwritten, overrun[k] set. A strobe on the grant edge of source k loads new data, leaves pending[k]=1, and does not set overrun.
- overrun_clr clears all flags; a new overrun event on the same edge wins (flag remains 1).
- FSM states: IDLE, ISSUE, GAP.
- IDLE: if any pending bit is set, select the first pending source searching rr_ptr, rr_ptr+1, ... mod NUM_SRC. On that edge: copy hold -> out_data_1/2, out_chan=index, pending cleared, rr_ptr=index+1 mod NUM_SRC, out_valid=1, go ISSUE. Grant is visible one cycle after the pending bit is seen in IDLE.
- ISSUE: out_valid and data are held stable until out_valid&&out_ready at an edge. On that edge: out_valid=0, counter=SLOT_GAP, go GAP. out_ready while not in ISSUE is ignored.
- GAP: counter decrements each cycle; at 1 -> IDLE. This gives exactly SLOT_GAP cycles with out_valid=0 before IDLE, then >=1 IDLE cycle before the next out_valid.
- Throughput with out_ready tied high: one pair per SLOT_GAP+2 cycles.
- Sources not granted keep pending data indefinitely; there is no timeout.
- busy = (state != IDLE), registered.

Optional Feature:
SCHED_FIXED_PRIO_EN: when defined, source 0 wins every IDLE arbitration it is pending in; the remaining sources round-robin among themselves, and rr_ptr never points to 0. When undefined, all sources use pure round-robin as above.

Test Plan:
- Reset: strobe all sources, then pulse reset_n low for 1 cycle -> all outputs 0, no out_valid for the following 10 cycles.
- Single source: strobe src0 with I=0x123456, Q=0xABCDEF, out_ready=1 -> out_valid high for 1 cycle with those values and out_chan=0; next out_valid is no earlier than SLOT_GAP+2 cycles later.
- Round-robin (NUM_SRC=2): strobe both sources on the same cycle, twice with spacing -> grant order 0,1,0,1; overrun stays 0.
- Backpressure: out_ready=0 for 7 cycles after out_valid -> data and out_chan are stable for all 7 cycles; exactly one transfer completes when ready rises.
- Overrun: strobe src1 twice (0x000001 then 0x000002) while ISSUE is held by src0 -> overrun[1]=1, src1 later issues 0x000002; overrun_clr -> overrun[1]=0.
- Grant-edge strobe: strobe src0 on its grant edge -> no overrun; src0 issues again after GAP.

Source files
------------

// File: rtl/iq_stream_scheduler.sv
// Round-robin scheduler sharing one I/Q valid/ready port between NUM_SRC held sources,
// with a SLOT_GAP guard gap after each transfer. Define SCHED_FIXED_PRIO_EN to give source 0 fixed priority.
module iq_stream_scheduler #(
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned SLOT_GAP = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_SRC-1:0]        src_strobe,
   input  logic [NUM_SRC*DATA_W-1:0] src_data_1,
   input  logic [NUM_SRC*DATA_W-1:0] src_data_2,
   output logic [DATA_W-1:0]         out_data_1,
   output logic [DATA_W-1:0]         out_data_2,
   output logic [1:0]                out_chan,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_SRC-1:0]        overrun,
   input  logic                      overrun_clr,
   output logic                      busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

`ifdef SCHED_FIXED_PRIO_EN
   localparam logic [1:0]  RR_FIRST = 2'd1;
   localparam int unsigned RR_LOW   = 1;
`else
   localparam logic [1:0]  RR_FIRST = 2'd0;
   localparam int unsigned RR_LOW   = 0;
`endif
   localparam logic [3:0] GAP_INIT = 4'(SLOT_GAP);

   state_t               state_q, state_d;
   logic [NUM_SRC-1:0]   pending_q, pending_d;
   logic [DATA_W-1:0]    hold_1_q [NUM_SRC];
   logic [DATA_W-1:0]    hold_1_d [NUM_SRC];
   logic [DATA_W-1:0]    hold_2_q [NUM_SRC];
   logic [DATA_W-1:0]    hold_2_d [NUM_SRC];
   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic [3:0]           gap_cnt_q, gap_cnt_d;
   logic [DATA_W-1:0]    out_data_1_q, out_data_1_d;
   logic [DATA_W-1:0]    out_data_2_q, out_data_2_d;
   logic [1:0]           out_chan_q, out_chan_d;
   logic                 out_valid_q, out_valid_d;
   logic [NUM_SRC-1:0]   overrun_q, overrun_d;
   logic                 busy_q, busy_d;

   logic                 grant_found;
   logic [1:0]           grant_idx;
   logic [NUM_SRC-1:0]   grant_oh;
   logic [1:0]           rr_next;
   logic                 granting;

   // Two-pass search: indices at/after rr_ptr first, then the wrapped-around ones below it.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
`ifdef SCHED_FIXED_PRIO_EN
      if (pending_q[0]) begin
         grant_found = 1'b1;
      end
`endif
      for (int unsigned k = RR_LOW; k < NUM_SRC; k++) begin
         if (!grant_found && pending_q[k] && (k >= 32'(rr_ptr_q))) begin
            grant_found = 1'b1;
            grant_idx   = 2'(k);
         end
      end
      for (int unsigned k = RR_LOW; k < NUM_SRC; k++) begin
         if (!grant_found && pending_q[k] && (k < 32'(rr_ptr_q))) begin
            grant_found = 1'b1;
            grant_idx   = 2'(k);
         end
      end
      grant_oh = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         grant_oh[k] = grant_found && (32'(grant_idx) == k);
      end
      if (32'(grant_idx) == NUM_SRC - 1) begin
         rr_next = RR_FIRST;
      end else begin
         rr_next = grant_idx + 2'd1;
      end
`ifdef SCHED_FIXED_PRIO_EN
      if (grant_idx == 2'd0) begin
         rr_next = rr_ptr_q;
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      hold_1_d     = hold_1_q;
      hold_2_d     = hold_2_q;
      rr_ptr_d     = rr_ptr_q;
      gap_cnt_d    = gap_cnt_q;
      out_data_1_d = out_data_1_q;
      out_data_2_d = out_data_2_q;
      out_chan_d   = out_chan_q;
      out_valid_d  = out_valid_q;
      overrun_d    = overrun_clr ? '0 : overrun_q;
      granting     = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_found) begin
               granting    = 1'b1;
               out_chan_d  = grant_idx;
               out_valid_d = 1'b1;
               rr_ptr_d    = rr_next;
               state_d     = ISSUE;
               for (int unsigned k = 0; k < NUM_SRC; k++) begin
                  if (grant_oh[k]) begin
                     out_data_1_d = hold_1_q[k];
                     out_data_2_d = hold_2_q[k];
                     pending_d[k] = 1'b0;
                  end
               end
            end
         end
         ISSUE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               gap_cnt_d   = GAP_INIT;
               state_d     = GAP;
            end
         end
         GAP: begin
            if (gap_cnt_q == 4'd1) begin
               gap_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A strobe on the source's own grant edge refills the register without counting as overrun.
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (src_strobe[k]) begin
            if (pending_q[k] && !(granting && grant_oh[k])) begin
               overrun_d[k] = 1'b1;
            end
            hold_1_d[k]  = src_data_1[k*DATA_W +: DATA_W];
            hold_2_d[k]  = src_data_2[k*DATA_W +: DATA_W];
            pending_d[k] = 1'b1;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         rr_ptr_q     <= RR_FIRST;
         gap_cnt_q    <= '0;
         out_data_1_q <= '0;
         out_data_2_q <= '0;
         out_chan_q   <= '0;
         out_valid_q  <= 1'b0;
         overrun_q    <= '0;
         busy_q       <= 1'b0;
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
            hold_1_q[k] <= '0;
            hold_2_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         rr_ptr_q     <= rr_ptr_d;
         gap_cnt_q    <= gap_cnt_d;
         out_data_1_q <= out_data_1_d;
         out_data_2_q <= out_data_2_d;
         out_chan_q   <= out_chan_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
         hold_1_q     <= hold_1_d;
         hold_2_q     <= hold_2_d;
      end
   end

   assign out_data_1 = out_data_1_q;
   assign out_data_2 = out_data_2_q;
   assign out_chan   = out_chan_q;
   assign out_valid  = out_valid_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_iq_stream_scheduler.sv
// Testbench for iq_stream_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_iq_stream_scheduler;

   localparam int unsigned NUM_SRC  = 2;
   localparam int unsigned DATA_W   = 24;
   localparam int unsigned SLOT_GAP = 4;

   logic                      clk = 1'b0;
   logic                      reset_n;
   logic [NUM_SRC-1:0]        src_strobe;
   logic [NUM_SRC*DATA_W-1:0] src_data_1;
   logic [NUM_SRC*DATA_W-1:0] src_data_2;
   logic [DATA_W-1:0]         out_data_1;
   logic [DATA_W-1:0]         out_data_2;
   logic [1:0]                out_chan;
   logic                      out_valid;
   logic                      out_ready;
   logic [NUM_SRC-1:0]        overrun;
   logic                      overrun_clr;
   logic                      busy;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   iq_stream_scheduler #(
      .NUM_SRC  (NUM_SRC),
      .DATA_W   (DATA_W),
      .SLOT_GAP (SLOT_GAP)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .src_strobe  (src_strobe),
      .src_data_1  (src_data_1),
      .src_data_2  (src_data_2),
      .out_data_1  (out_data_1),
      .out_data_2  (out_data_2),
      .out_chan    (out_chan),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr),
      .busy        (busy)
   );

   // Reference model: the next arbitration is allowed on any edge after gap_end,
   // which is set SLOT_GAP edges past each completed transfer.
   bit                 m_pend [NUM_SRC];
   logic [DATA_W-1:0]  m_h1   [NUM_SRC];
   logic [DATA_W-1:0]  m_h2   [NUM_SRC];
   bit                 m_issue = 1'b0;
   longint             m_gap_end = 0;
   longint             edge_n = 0;
   int                 m_rr = 0;
   logic [NUM_SRC-1:0] m_ov = '0;
   logic [DATA_W-1:0]  m_d1 = '0;
   logic [DATA_W-1:0]  m_d2 = '0;
   logic [1:0]         m_ch = '0;
   logic               m_val = 1'b0;
   logic               m_busy = 1'b0;

   task automatic step();
      int g;
      @(posedge clk);
      g = -1;
      if (!reset_n) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            m_pend[k] = 1'b0;
            m_h1[k]   = '0;
            m_h2[k]   = '0;
         end
         m_issue   = 1'b0;
         m_rr      = 0;
         m_ov      = '0;
         m_d1      = '0;
         m_d2      = '0;
         m_ch      = '0;
         m_val     = 1'b0;
         m_gap_end = edge_n;
      end else begin
         if (m_issue) begin
            if (out_ready) begin
               m_issue   = 1'b0;
               m_val     = 1'b0;
               m_gap_end = edge_n + longint'(SLOT_GAP);
            end
         end else if (edge_n > m_gap_end) begin
            for (int i = 0; i < NUM_SRC; i++) begin
               int k;
               k = (m_rr + i) % NUM_SRC;
               if (g < 0 && m_pend[k]) g = k;
            end
            if (g >= 0) begin
               m_d1      = m_h1[g];
               m_d2      = m_h2[g];
               m_ch      = 2'(g);
               m_pend[g] = 1'b0;
               m_rr      = (g + 1) % NUM_SRC;
               m_val     = 1'b1;
               m_issue   = 1'b1;
            end
         end
         if (overrun_clr) m_ov = '0;
         for (int k = 0; k < NUM_SRC; k++) begin
            if (src_strobe[k]) begin
               if (m_pend[k]) m_ov[k] = 1'b1;
               m_h1[k]   = src_data_1[k*DATA_W +: DATA_W];
               m_h2[k]   = src_data_2[k*DATA_W +: DATA_W];
               m_pend[k] = 1'b1;
            end
         end
      end
      m_busy = m_issue || (edge_n < m_gap_end);
      edge_n++;
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      src_strobe  = '0;
      src_data_1  = '0;
      src_data_2  = '0;
      out_ready   = 1'b0;
      overrun_clr = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_chan !== 2'd0 || overrun !== '0 ||
          out_data_1 !== '0 || out_data_2 !== '0) begin
         miscompares++;
         $display("FAIL reset_state: valid=%b busy=%b chan=%0d ovr=%b d1=%h d2=%h, required all zero",
                  out_valid, busy, out_chan, overrun, out_data_1, out_data_2);
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         src_data_1[k*DATA_W +: DATA_W] = DATA_W'($urandom());
         src_data_2[k*DATA_W +: DATA_W] = DATA_W'($urandom());
      end
      src_strobe = '1;
      step();
      src_strobe = '0;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_chan !== 2'd0 || overrun !== '0 ||
          out_data_1 !== '0 || out_data_2 !== '0) begin
         miscompares++;
         $display("FAIL reset_midflight: valid=%b busy=%b chan=%0d ovr=%b d1=%h d2=%h, required all zero",
                  out_valid, busy, out_chan, overrun, out_data_1, out_data_2);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_quiet[%0d]: valid=%b busy=%b, required 0 0", i, out_valid, busy);
         end
      end
   endtask

   task automatic test_single();
      int n;
      out_ready = 1'b1;
      src_data_1[0 +: DATA_W] = 24'h123456;
      src_data_2[0 +: DATA_W] = 24'hABCDEF;
      src_strobe[0] = 1'b1;
      step();
      src_strobe = '0;
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data_1 !== 24'h123456 || out_data_2 !== 24'hABCDEF) begin
         miscompares++;
         $display("FAIL single_grant: valid=%b chan=%0d d1=%h d2=%h, required 1 0 123456 abcdef",
                  out_valid, out_chan, out_data_1, out_data_2);
      end
      src_data_1[0 +: DATA_W] = 24'h111111;
      src_data_2[0 +: DATA_W] = 24'h222222;
      src_strobe[0] = 1'b1;
      step();
      src_strobe = '0;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_one_cycle: valid=%b, required 0", out_valid);
      end
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      vectors++;
      if (n != SLOT_GAP + 1) begin
         miscompares++;
         $display("FAIL single_spacing: valid-to-valid %0d cycles, required %0d", n + 1, SLOT_GAP + 2);
      end
      vectors++;
      if (out_chan !== 2'd0 || out_data_1 !== 24'h111111 || out_data_2 !== 24'h222222) begin
         miscompares++;
         $display("FAIL single_second: chan=%0d d1=%h d2=%h, required 0 111111 222222",
                  out_chan, out_data_1, out_data_2);
      end
      repeat (SLOT_GAP + 3) step();
   endtask

   task automatic test_round_robin();
      int                e_ch [$];
      logic [DATA_W-1:0] e_d1 [$];
      logic [DATA_W-1:0] e_d2 [$];
      int                g_ch [$];
      logic [DATA_W-1:0] g_d1 [$];
      logic [DATA_W-1:0] g_d2 [$];
      logic [DATA_W-1:0] d1, d2;
      do_reset();
      out_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            d1 = DATA_W'($urandom());
            d2 = DATA_W'($urandom());
            src_data_1[k*DATA_W +: DATA_W] = d1;
            src_data_2[k*DATA_W +: DATA_W] = d2;
            e_ch.push_back(k);
            e_d1.push_back(d1);
            e_d2.push_back(d2);
         end
         src_strobe = '1;
         step();
         src_strobe = '0;
         repeat (20) begin
            step();
            if (out_valid === 1'b1) begin
               g_ch.push_back(int'(out_chan));
               g_d1.push_back(out_data_1);
               g_d2.push_back(out_data_2);
            end
         end
      end
      vectors++;
      if (g_ch.size() != e_ch.size()) begin
         miscompares++;
         $display("FAIL rr_count: %0d grants, required %0d", g_ch.size(), e_ch.size());
      end else begin
         for (int i = 0; i < e_ch.size(); i++) begin
            vectors++;
            if (g_ch[i] != e_ch[i] || g_d1[i] !== e_d1[i] || g_d2[i] !== e_d2[i]) begin
               miscompares++;
               $display("FAIL rr_grant[%0d]: chan=%0d d1=%h d2=%h, required %0d %h %h",
                        i, g_ch[i], g_d1[i], g_d2[i], e_ch[i], e_d1[i], e_d2[i]);
            end
         end
      end
      vectors++;
      if (overrun !== '0) begin
         miscompares++;
         $display("FAIL rr_overrun: ovr=%b, required 0", overrun);
      end
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] d1, d2;
      int                xfers;
      do_reset();
      out_ready = 1'b0;
      d1 = DATA_W'($urandom());
      d2 = DATA_W'($urandom());
      src_data_1[DATA_W +: DATA_W] = d1;
      src_data_2[DATA_W +: DATA_W] = d2;
      src_strobe[1] = 1'b1;
      step();
      src_strobe = '0;
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data_1 !== d1 || out_data_2 !== d2) begin
         miscompares++;
         $display("FAIL bp_grant: valid=%b chan=%0d d1=%h d2=%h, required 1 1 %h %h",
                  out_valid, out_chan, out_data_1, out_data_2, d1, d2);
      end
      for (int i = 0; i < 7; i++) begin
         step();
         vectors++;
         if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data_1 !== d1 || out_data_2 !== d2) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: valid=%b chan=%0d d1=%h d2=%h, required 1 1 %h %h",
                     i, out_valid, out_chan, out_data_1, out_data_2, d1, d2);
         end
      end
      out_ready = 1'b1;
      xfers = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid === 1'b1) xfers++;
         step();
      end
      vectors++;
      if (xfers != 1) begin
         miscompares++;
         $display("FAIL bp_xfers: %0d transfers, required 1", xfers);
      end
   endtask

   task automatic test_overrun();
      logic [DATA_W-1:0]  a1, a2, q2;
      logic [NUM_SRC-1:0] e_ov;
      int                 g_ch [$];
      logic [DATA_W-1:0]  g_d1 [$];
      logic [DATA_W-1:0]  g_d2 [$];
      do_reset();
      out_ready = 1'b0;
      e_ov = '0;
      e_ov[1] = 1'b1;
      a1 = DATA_W'($urandom());
      a2 = DATA_W'($urandom());
      src_data_1[0 +: DATA_W] = a1;
      src_data_2[0 +: DATA_W] = a2;
      src_strobe[0] = 1'b1;
      step();
      src_strobe = '0;
      step();
      src_data_1[DATA_W +: DATA_W] = 24'h000001;
      src_data_2[DATA_W +: DATA_W] = DATA_W'($urandom());
      src_strobe[1] = 1'b1;
      step();
      q2 = DATA_W'($urandom());
      src_data_1[DATA_W +: DATA_W] = 24'h000002;
      src_data_2[DATA_W +: DATA_W] = q2;
      step();
      src_strobe = '0;
      vectors++;
      if (overrun !== e_ov) begin
         miscompares++;
         $display("FAIL ovr_set: ovr=%b, required %b", overrun, e_ov);
      end
      out_ready = 1'b1;
      repeat (20) begin
         if (out_valid === 1'b1) begin
            g_ch.push_back(int'(out_chan));
            g_d1.push_back(out_data_1);
            g_d2.push_back(out_data_2);
         end
         step();
      end
      vectors++;
      if (g_ch.size() != 2) begin
         miscompares++;
         $display("FAIL ovr_count: %0d transfers, required 2", g_ch.size());
      end else begin
         vectors++;
         if (g_ch[0] != 0 || g_d1[0] !== a1 || g_d2[0] !== a2) begin
            miscompares++;
            $display("FAIL ovr_first: chan=%0d d1=%h d2=%h, required 0 %h %h", g_ch[0], g_d1[0], g_d2[0], a1, a2);
         end
         vectors++;
         if (g_ch[1] != 1 || g_d1[1] !== 24'h000002 || g_d2[1] !== q2) begin
            miscompares++;
            $display("FAIL ovr_latest: chan=%0d d1=%h d2=%h, required 1 000002 %h", g_ch[1], g_d1[1], g_d2[1], q2);
         end
      end
      vectors++;
      if (overrun !== e_ov) begin
         miscompares++;
         $display("FAIL ovr_sticky: ovr=%b, required %b", overrun, e_ov);
      end
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      vectors++;
      if (overrun !== '0) begin
         miscompares++;
         $display("FAIL ovr_clear: ovr=%b, required 0", overrun);
      end
   endtask

   task automatic test_grant_edge();
      logic [DATA_W-1:0] x1, x2, y1, y2;
      int                n;
      do_reset();
      out_ready = 1'b1;
      x1 = DATA_W'($urandom());
      x2 = DATA_W'($urandom());
      y1 = DATA_W'($urandom());
      y2 = DATA_W'($urandom());
      src_data_1[0 +: DATA_W] = x1;
      src_data_2[0 +: DATA_W] = x2;
      src_strobe[0] = 1'b1;
      step();
      src_data_1[0 +: DATA_W] = y1;
      src_data_2[0 +: DATA_W] = y2;
      step();
      src_strobe = '0;
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data_1 !== x1 || out_data_2 !== x2) begin
         miscompares++;
         $display("FAIL ge_grant: valid=%b chan=%0d d1=%h d2=%h, required 1 0 %h %h",
                  out_valid, out_chan, out_data_1, out_data_2, x1, x2);
      end
      vectors++;
      if (overrun !== '0) begin
         miscompares++;
         $display("FAIL ge_no_overrun: ovr=%b, required 0", overrun);
      end
      step();
      n = 1;
      while (out_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      vectors++;
      if (n != SLOT_GAP + 2 || out_chan !== 2'd0 || out_data_1 !== y1 || out_data_2 !== y2) begin
         miscompares++;
         $display("FAIL ge_reissue: after %0d cycles chan=%0d d1=%h d2=%h, required %0d 0 %h %h",
                  n, out_chan, out_data_1, out_data_2, SLOT_GAP + 2, y1, y2);
      end
      vectors++;
      if (overrun !== '0) begin
         miscompares++;
         $display("FAIL ge_overrun_after: ovr=%b, required 0", overrun);
      end
      repeat (SLOT_GAP + 3) step();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            src_strobe[k] = ($urandom_range(0, 3) == 0);
            src_data_1[k*DATA_W +: DATA_W] = DATA_W'($urandom());
            src_data_2[k*DATA_W +: DATA_W] = DATA_W'($urandom());
         end
         out_ready   = ($urandom_range(0, 9) < 7);
         overrun_clr = ($urandom_range(0, 39) == 0);
         reset_n     = ($urandom_range(0, 299) != 0);
         step();
         vectors++;
         if (out_valid !== m_val) begin
            miscompares++;
            $display("FAIL rnd_valid[%0d]: valid=%b, required %b", c, out_valid, m_val);
         end
         vectors++;
         if (out_chan !== m_ch || out_data_1 !== m_d1 || out_data_2 !== m_d2) begin
            miscompares++;
            $display("FAIL rnd_data[%0d]: chan=%0d d1=%h d2=%h, required %0d %h %h",
                     c, out_chan, out_data_1, out_data_2, m_ch, m_d1, m_d2);
         end
         vectors++;
         if (overrun !== m_ov) begin
            miscompares++;
            $display("FAIL rnd_overrun[%0d]: ovr=%b, required %b", c, overrun, m_ov);
         end
         vectors++;
         if (busy !== m_busy) begin
            miscompares++;
            $display("FAIL rnd_busy[%0d]: busy=%b, required %b", c, busy, m_busy);
         end
      end
      src_strobe  = '0;
      overrun_clr = 1'b0;
      reset_n     = 1'b1;
   endtask

   initial begin
      reset_n     = 1'b0;
      src_strobe  = '0;
      src_data_1  = '0;
      src_data_2  = '0;
      out_ready   = 1'b0;
      overrun_clr = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_overrun();
      test_grant_edge();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
